// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage stall/flush master, control-register file, exception/EXRT/interrupt commit
module pipeline_ctrl #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IRQ_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy,
  input  logic              ld_hazard,
  input  logic              mem_busy,
  input  logic              id_en,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [4:0]        mem_dst_addr,
  input  logic [2:0]        mem_exp_code,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [IRQ_W-1:0]  irq,
  input  logic [4:0]        creg_rd_addr,
  output logic [DATA_W-1:0] creg_rd_data,
  output logic              exe_mode,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc
);
  logic [1:0]        status, pre_status;
  logic [ADDR_W-1:0] epc, exp_vec;
  logic [2:0]        cause;
  logic [IRQ_W-1:0]  int_mask, irq_pend, irq_s1, irq_s2;
  logic stall, live, exc, exrt, wrcr, intr, flush_all, unused_ok;
  assign unused_ok = ^mem_out;
  assign stall = if_busy | ld_hazard | mem_busy;
  assign live  = ~rst & mem_en & ~mem_busy;
  assign exc   = live & (|mem_exp_code);
  assign exrt  = live & ~exc & (mem_ctrl_op == 2'd2);
  assign wrcr  = live & ~exc & (mem_ctrl_op == 2'd1);
  // interrupts enter at ID only when nothing in MEM is committing this cycle
  assign intr  = ~rst & status[1] & (|(irq_pend & ~int_mask)) & id_en & ~stall & ~exc & ~exrt & ~wrcr;
  assign flush_all = exc | exrt;
  assign if_stall  = ~rst & stall;
  assign id_stall  = ~rst & stall;
  assign ex_stall  = ~rst & mem_busy;
  assign mem_stall = ~rst & mem_busy;
  assign if_flush  = flush_all | intr;
  assign id_flush  = flush_all | intr | (~rst & ld_hazard & ~mem_busy);
  assign ex_flush  = flush_all;
  assign mem_flush = flush_all;
  assign new_pc    = exrt ? epc : (exc | intr) ? exp_vec : '0;
  assign exe_mode  = status[0];
  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      5'd0: creg_rd_data = DATA_W'(status);
      5'd1: creg_rd_data = DATA_W'(pre_status);
      5'd2: creg_rd_data = DATA_W'(epc);
      5'd3: creg_rd_data = DATA_W'(exp_vec);
      5'd4: creg_rd_data = DATA_W'(cause);
      5'd5: creg_rd_data = DATA_W'(int_mask);
      5'd6: creg_rd_data = DATA_W'(irq_pend);
      default: creg_rd_data = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= '0;
      pre_status <= '0;
      epc        <= '0;
      exp_vec    <= '0;
      cause      <= '0;
      int_mask   <= '1;
      irq_pend   <= '0;
      irq_s1     <= '0;
      irq_s2     <= '0;
    end else begin
      irq_s1   <= irq;
      irq_s2   <= irq_s1;
      irq_pend <= (wrcr && mem_dst_addr == 5'd6) ? irq_pend & ~mem_out[IRQ_W-1:0] : irq_pend | irq_s2;
      if (exc | intr) begin
        pre_status <= status;
        status     <= '0;
        epc        <= exc ? mem_pc : id_pc;
        cause      <= exc ? mem_exp_code : 3'd1;
      end else if (exrt) begin
        status <= pre_status;
      end else if (wrcr) begin
        case (mem_dst_addr)
          5'd0: status     <= mem_out[1:0];
          5'd1: pre_status <= mem_out[1:0];
          5'd2: epc        <= mem_out[ADDR_W-1:0];
          5'd3: exp_vec    <= mem_out[ADDR_W-1:0];
          5'd4: cause      <= mem_out[2:0];
          5'd5: int_mask   <= mem_out[IRQ_W-1:0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic clk = 0, rst = 0, if_busy = 0, ld_hazard = 0, mem_busy = 0, id_en = 0, mem_en = 0;
  logic [29:0] id_pc = '0, mem_pc = '0, new_pc;
  logic [1:0]  mem_ctrl_op = '0;
  logic [4:0]  mem_dst_addr = '0, creg_rd_addr = '0;
  logic [2:0]  mem_exp_code = '0;
  logic [31:0] mem_out = '0, creg_rd_data;
  logic [7:0]  irq = '0;
  logic exe_mode, if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush;
  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0, fails = 0;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .if_busy(if_busy), .ld_hazard(ld_hazard), .mem_busy(mem_busy),
    .id_en(id_en), .id_pc(id_pc), .mem_en(mem_en), .mem_pc(mem_pc), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code), .mem_out(mem_out), .irq(irq),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data), .exe_mode(exe_mode),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc)
  );

  always #20 clk = ~clk;

  task automatic push(input string t, input logic [31:0] e);
    exp_t x;
    x.tag = t;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %h expected nothing", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) passes++;
      else begin
        fails++;
        $error("FAIL %s: got %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_ctl(input string t, input logic [7:0] e);
    push(t, 32'(e));
    #1;
    cmp(32'({if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush}));
  endtask

  task automatic chk_pc(input string t, input logic [29:0] e);
    push(t, 32'(e));
    #1;
    cmp(32'(new_pc));
  endtask

  task automatic chk_mode(input string t, input logic e);
    push(t, 32'(e));
    #1;
    cmp(32'(exe_mode));
  endtask

  task automatic rd(input string t, input logic [4:0] a, input logic [31:0] e);
    creg_rd_addr = a;
    push(t, e);
    #1;
    cmp(creg_rd_data);
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
    mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = a; mem_out = d;
    step();
    mem_en = 0; mem_ctrl_op = 2'd0;
  endtask

  initial begin
    rst = 1; if_busy = 1; ld_hazard = 1; mem_en = 1; mem_exp_code = 3'd4;
    step();
    chk_ctl("rst_ctl", 8'h00);
    chk_pc("rst_pc", 30'h0);
    step();
    rst = 0; if_busy = 0; ld_hazard = 0; mem_en = 0; mem_exp_code = 0;
    #1;
    rd("r0", 0, 0); rd("r1", 1, 0); rd("r2", 2, 0); rd("r3", 3, 0);
    rd("r4", 4, 0); rd("r5", 5, 32'hFF); rd("r6", 6, 0); rd("r7", 7, 0);
    chk_mode("rst_mode", 0);
    chk_ctl("idle_ctl", 8'h00);
    ld_hazard = 1;
    chk_ctl("ld_hazard", 8'b1100_0100);
    mem_busy = 1;
    chk_ctl("ld_hazard_membusy", 8'b1111_0000);
    step();
    ld_hazard = 0; mem_busy = 0;
    mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd3; mem_out = 32'h100;
    rd("wrcr_same_cycle_old", 3, 0);
    chk_ctl("wrcr_no_flush", 8'h00);
    step();
    mem_en = 0; mem_ctrl_op = 0;
    wrcr(0, 3);
    rd("expvec", 3, 32'h100);
    rd("status3", 0, 3);
    chk_mode("user_mode", 1);
    mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h40;
    chk_ctl("exc_flush", 8'h0F);
    chk_pc("exc_pc", 30'h100);
    step();
    mem_en = 0; mem_exp_code = 0;
    rd("exc_status", 0, 0); rd("exc_pre", 1, 3); rd("exc_epc", 2, 32'h40); rd("exc_cause", 4, 4);
    mem_en = 1; mem_ctrl_op = 2'd2;
    chk_ctl("exrt_flush", 8'h0F);
    chk_pc("exrt_pc", 30'h40);
    step();
    mem_en = 0; mem_ctrl_op = 0;
    rd("exrt_status", 0, 3);
    wrcr(5, 32'hFE);
    wrcr(0, 2);
    id_en = 1; id_pc = 30'h80; irq = 8'h01;
    step();
    irq = 0;
    chk_ctl("irq_sync1", 8'h00);
    step();
    chk_ctl("irq_sync2", 8'h00);
    rd("pend_not_yet", 6, 0);
    step();
    rd("pend_set", 6, 1);
    chk_ctl("int_flush", 8'b0000_1100);
    chk_pc("int_pc", 30'h100);
    step();
    chk_ctl("int_one_shot", 8'h00);
    rd("int_epc", 2, 32'h80); rd("int_cause", 4, 1); rd("int_status", 0, 0); rd("int_pre", 1, 2);
    wrcr(6, 1);
    rd("pend_w1c", 6, 0);
    id_en = 0; irq = 8'h01;
    wrcr(0, 2);
    step(); step(); step();
    irq = 0;
    rd("pend_again", 6, 1);
    id_en = 1; mem_en = 1; mem_exp_code = 3'd6; mem_pc = 30'h44; mem_busy = 1;
    chk_ctl("busy_no_commit", 8'hF0);
    step();
    rd("busy_status", 0, 2); rd("busy_cause", 4, 1); rd("busy_epc", 2, 32'h80);
    mem_busy = 0;
    chk_ctl("exc_over_int", 8'h0F);
    chk_pc("exc_over_int_pc", 30'h100);
    step();
    mem_en = 0; mem_exp_code = 0;
    rd("sim_cause", 4, 6); rd("sim_epc", 2, 32'h44); rd("sim_status", 0, 0); rd("sim_pre", 1, 2);
    rd("int_deferred", 6, 1);
    chk_ctl("int_masked_by_status", 8'h00);
    rst = 1; mem_en = 1; mem_exp_code = 3'd4;
    chk_ctl("rst_mid_event", 8'h00);
    step();
    rst = 0; mem_en = 0; mem_exp_code = 0; id_en = 0;
    rd("rst_mask", 5, 32'hFF); rd("rst_pend", 6, 0); rd("rst_epc", 2, 0); rd("rst_vec", 3, 0);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
